// File: rtl/riscky_pkg.sv
// ============================================================================
// Module      : riscky_pkg
// Description : Shared datapath widths and ALU operation codes for the
//               riscky pipeline.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package riscky_pkg;

  // Default datapath and register-index widths
  localparam int XLEN_DEFAULT  = 32;
  localparam int RADDR_DEFAULT = 5;

  // ALU operation codes carried through ALUControl
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

endpackage : riscky_pkg

`default_nettype wire

// File: rtl/operand_fwd_mux.sv
// ============================================================================
// Module      : operand_fwd_mux
// Description : Priority operand select for one source register:
//               MEM result, then WB result, then held register-file data.
//               Register x0 is never forwarded.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module operand_fwd_mux
  import riscky_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int RADDR = RADDR_DEFAULT
) (
  input  logic [RADDR-1:0] i_rs,
  input  logic [XLEN-1:0]  i_held_data,
  input  logic             i_mem_valid,
  input  logic [RADDR-1:0] i_mem_rd,
  input  logic [XLEN-1:0]  i_mem_data,
  input  logic             i_wb_valid,
  input  logic [RADDR-1:0] i_wb_rd,
  input  logic [XLEN-1:0]  i_wb_data,
  output logic [XLEN-1:0]  o_data
);

  logic w_rs_nonzero;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_rs_nonzero = (i_rs != '0);
  assign w_mem_hit    = w_rs_nonzero && i_mem_valid && (i_mem_rd == i_rs);
  assign w_wb_hit     = w_rs_nonzero && i_wb_valid  && (i_wb_rd  == i_rs);

  // MEM is the younger producer, so it takes priority over WB
  always_comb begin
    o_data = i_held_data;
    if (w_mem_hit) begin
      o_data = i_mem_data;
    end else if (w_wb_hit) begin
      o_data = i_wb_data;
    end
  end

endmodule : operand_fwd_mux

`default_nettype wire

// File: rtl/alu_operand_stage.sv
// ============================================================================
// Module      : alu_operand_stage
// Description : Single-entry pipeline register ahead of the ALU. Captures a
//               decoded instruction per handshake, resolves RAW hazards
//               against MEM/WB and drives A, B and ALUControl.
//               Build option ALU_OPERAND_FWD_EN enables the forwarding muxes
//               and the stall-time refresh of held operands.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_operand_stage
  import riscky_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int RADDR = RADDR_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  // decode side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RADDR-1:0] in_rs1,
  input  logic [RADDR-1:0] in_rs2,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_alu_src,
  input  logic [2:0]       in_alu_control,
  input  logic [RADDR-1:0] in_rd,
  input  logic             in_reg_write,
  input  logic             flush,
  // forwarding sources
  input  logic             fwd_mem_valid,
  input  logic [RADDR-1:0] fwd_mem_rd,
  input  logic [XLEN-1:0]  fwd_mem_data,
  input  logic             fwd_wb_valid,
  input  logic [RADDR-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0]  fwd_wb_data,
  // ALU side
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  A,
  output logic [XLEN-1:0]  B,
  output logic [2:0]       ALUControl,
  output logic [XLEN-1:0]  out_store_data,
  output logic [RADDR-1:0] out_rd,
  output logic             out_reg_write
);

  // Held entry
  logic             r_valid;
  logic [RADDR-1:0] r_rs1;
  logic [RADDR-1:0] r_rs2;
  logic [XLEN-1:0]  r_rs1_data;
  logic [XLEN-1:0]  r_rs2_data;
  logic [XLEN-1:0]  r_imm;
  logic             r_alu_src;
  logic [2:0]       r_alu_control;
  logic [RADDR-1:0] r_rd;
  logic             r_reg_write;

  logic             w_capture;
  logic [XLEN-1:0]  w_fwd_rs1;
  logic [XLEN-1:0]  w_fwd_rs2;

  assign in_ready  = !r_valid || out_ready;
  // Flush suppresses capture; in_ready itself is left alone
  assign w_capture = in_valid && in_ready && !flush;

`ifdef ALU_OPERAND_FWD_EN
  logic w_rs1_refresh;
  logic w_rs2_refresh;

  // A WB hit during a stall is written back into the entry so the value
  // survives after the producer leaves the pipeline
  assign w_rs1_refresh = fwd_wb_valid && (r_rs1 != '0) && (fwd_wb_rd == r_rs1);
  assign w_rs2_refresh = fwd_wb_valid && (r_rs2 != '0) && (fwd_wb_rd == r_rs2);

  operand_fwd_mux #(
    .XLEN  (XLEN),
    .RADDR (RADDR)
  ) u_fwd_rs1 (
    .i_rs        (r_rs1),
    .i_held_data (r_rs1_data),
    .i_mem_valid (fwd_mem_valid),
    .i_mem_rd    (fwd_mem_rd),
    .i_mem_data  (fwd_mem_data),
    .i_wb_valid  (fwd_wb_valid),
    .i_wb_rd     (fwd_wb_rd),
    .i_wb_data   (fwd_wb_data),
    .o_data      (w_fwd_rs1)
  );

  operand_fwd_mux #(
    .XLEN  (XLEN),
    .RADDR (RADDR)
  ) u_fwd_rs2 (
    .i_rs        (r_rs2),
    .i_held_data (r_rs2_data),
    .i_mem_valid (fwd_mem_valid),
    .i_mem_rd    (fwd_mem_rd),
    .i_mem_data  (fwd_mem_data),
    .i_wb_valid  (fwd_wb_valid),
    .i_wb_rd     (fwd_wb_rd),
    .i_wb_data   (fwd_wb_data),
    .o_data      (w_fwd_rs2)
  );
`else
  logic w_unused_fwd;

  // Without forwarding the stall logic owns hazards; operands come straight
  // from the held register data and the fwd_* ports are ignored
  assign w_fwd_rs1    = r_rs1_data;
  assign w_fwd_rs2    = r_rs2_data;
  assign w_unused_fwd = ^{fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                          fwd_wb_valid, fwd_wb_rd, fwd_wb_data, r_rs1, r_rs2};
`endif

  // Entry valid tracking, capture of new instruction and stall refresh
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid       <= 1'b0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_rs1_data    <= '0;
      r_rs2_data    <= '0;
      r_imm         <= '0;
      r_alu_src     <= 1'b0;
      r_alu_control <= 3'b000;
      r_rd          <= '0;
      r_reg_write   <= 1'b0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_capture) begin
        r_valid <= 1'b1;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end

      if (w_capture) begin
        r_rs1         <= in_rs1;
        r_rs2         <= in_rs2;
        r_rs1_data    <= in_rs1_data;
        r_rs2_data    <= in_rs2_data;
        r_imm         <= in_imm;
        r_alu_src     <= in_alu_src;
        r_alu_control <= in_alu_control;
        r_rd          <= in_rd;
        r_reg_write   <= in_reg_write;
      end
`ifdef ALU_OPERAND_FWD_EN
      else if (r_valid) begin
        if (w_rs1_refresh) begin
          r_rs1_data <= fwd_wb_data;
        end
        if (w_rs2_refresh) begin
          r_rs2_data <= fwd_wb_data;
        end
      end
`endif
    end
  end

  assign out_valid      = r_valid;
  assign A              = w_fwd_rs1;
  assign B              = r_alu_src ? r_imm : w_fwd_rs2;
  assign out_store_data = w_fwd_rs2;
  assign ALUControl     = r_alu_control;
  assign out_rd         = r_rd;
  assign out_reg_write  = r_valid && r_reg_write;

endmodule : alu_operand_stage

`default_nettype wire
